// File: rtl/vram_arbiter_if.sv
// Bus bundle between the VRAM arbiter, the sync/pixel-fetch side, the CPU bridge and the RAM.
// The arbiter uses the slave modport; the surrounding logic (or a bench) uses master.
interface vram_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned WAIT_WIDTH = 16
);
  logic                  i_hblank;
  logic                  i_vblank;
  logic                  i_vid_req;
  logic [ADDR_WIDTH-1:0] i_vid_addr;
  logic                  o_vid_valid;
  logic [DATA_WIDTH-1:0] o_vid_data;
  logic                  i_cpu_req;
  logic                  i_cpu_we;
  logic [ADDR_WIDTH-1:0] i_cpu_addr;
  logic [DATA_WIDTH-1:0] i_cpu_wdata;
  logic                  o_cpu_ack;
  logic [DATA_WIDTH-1:0] o_cpu_rdata;
  logic [WAIT_WIDTH-1:0] o_cpu_wait;
  logic                  o_mem_en;
  logic                  o_mem_we;
  logic [ADDR_WIDTH-1:0] o_mem_addr;
  logic [DATA_WIDTH-1:0] o_mem_wdata;
  logic [DATA_WIDTH-1:0] i_mem_rdata;

  modport slave (
    input  i_hblank, i_vblank, i_vid_req, i_vid_addr,
    input  i_cpu_req, i_cpu_we, i_cpu_addr, i_cpu_wdata, i_mem_rdata,
    output o_vid_valid, o_vid_data, o_cpu_ack, o_cpu_rdata, o_cpu_wait,
    output o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata
  );

  modport master (
    output i_hblank, i_vblank, i_vid_req, i_vid_addr,
    output i_cpu_req, i_cpu_we, i_cpu_addr, i_cpu_wdata, i_mem_rdata,
    input  o_vid_valid, o_vid_data, o_cpu_ack, o_cpu_rdata, o_cpu_wait,
    input  o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata
  );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: video fetches always win, CPU accesses fill idle (blanking) cycles.
// Read data returns two cycles after issue through a tag pipeline.
module vram_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CPU_ANY_TIME = 0,
  parameter int unsigned WAIT_WIDTH   = 16
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  vram_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CPU_BUSY = 2'd1,
    ST_CPU_ACK  = 2'd2
  } state_t;

  state_t state;
  state_t state_next;
  logic   cpu_issue_c;
  logic   blank_ok_c;
  logic   first_seen_c;
  logic   pending;
  logic   tag_vld;
  logic   tag_cpu;
  logic   tag_rd;

  assign blank_ok_c   = (CPU_ANY_TIME != 0) || bus.i_hblank || bus.i_vblank;
  assign first_seen_c = (state == ST_IDLE) && bus.i_cpu_req && !pending;

  // Next state and CPU grant; video requests pre-empt a grantable CPU request
  always_comb begin
    state_next  = state;
    cpu_issue_c = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.i_cpu_req && blank_ok_c && !bus.i_vid_req) begin
          cpu_issue_c = 1'b1;
          state_next  = ST_CPU_BUSY;
        end
      end
      ST_CPU_BUSY: state_next = ST_CPU_ACK;
      ST_CPU_ACK:  state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  // Memory port follows the current-cycle grant; held quiet while in reset
  always_comb begin
    bus.o_mem_en    = 1'b0;
    bus.o_mem_we    = 1'b0;
    bus.o_mem_addr  = '0;
    bus.o_mem_wdata = '0;
    if (i_rst_n) begin
      if (bus.i_vid_req) begin
        bus.o_mem_en   = 1'b1;
        bus.o_mem_addr = bus.i_vid_addr;
      end else if (cpu_issue_c) begin
        bus.o_mem_en    = 1'b1;
        bus.o_mem_we    = bus.i_cpu_we;
        bus.o_mem_addr  = bus.i_cpu_addr;
        bus.o_mem_wdata = bus.i_cpu_wdata;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state           <= ST_IDLE;
      pending         <= 1'b0;
      tag_vld         <= 1'b0;
      tag_cpu         <= 1'b0;
      tag_rd          <= 1'b0;
      bus.o_vid_valid <= 1'b0;
      bus.o_vid_data  <= '0;
      bus.o_cpu_ack   <= 1'b0;
      bus.o_cpu_rdata <= '0;
      bus.o_cpu_wait  <= '0;
    end else begin
      state   <= state_next;
      pending <= (state == ST_IDLE) && bus.i_cpu_req && !cpu_issue_c;

      // Stage 0 tags the issue; stage 1 captures the RAM's registered read data
      tag_vld <= bus.i_vid_req || cpu_issue_c;
      tag_cpu <= cpu_issue_c;
      tag_rd  <= !bus.i_cpu_we;

      bus.o_vid_valid <= tag_vld && !tag_cpu;
      if (tag_vld && !tag_cpu) bus.o_vid_data <= bus.i_mem_rdata;
      bus.o_cpu_ack <= (state == ST_CPU_BUSY);
      if (tag_vld && tag_cpu && tag_rd) bus.o_cpu_rdata <= bus.i_mem_rdata;

      // Wait count restarts per request and saturates at all-ones
      if (first_seen_c) begin
        bus.o_cpu_wait <= cpu_issue_c ? '0 : WAIT_WIDTH'(1);
      end else if (pending && bus.i_cpu_req && !cpu_issue_c && (bus.o_cpu_wait != '1)) begin
        bus.o_cpu_wait <= bus.o_cpu_wait + WAIT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: a cycle-scheduled behavioural model checked every cycle,
// plus hand-computed literal expectations for each scenario.
module tb_vram_arbiter;
  localparam int unsigned AW      = 16;
  localparam int unsigned DW      = 8;
  localparam int unsigned WW      = 4;
  localparam int unsigned ANYTIME = 0;
  localparam int          WMAX    = (1 << WW) - 1;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  vram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_WIDTH(WW)) bus ();

  vram_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CPU_ANY_TIME(ANYTIME), .WAIT_WIDTH(WW)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM seen by the DUT, plus an independent shadow used by the model
  logic [7:0] ram  [0:65535];
  logic [7:0] mram [0:65535];

  always @(posedge clk) begin
    if (bus.o_mem_en) begin
      if (bus.o_mem_we) ram[bus.o_mem_addr] <= bus.o_mem_wdata;
      else              bus.i_mem_rdata     <= ram[bus.o_mem_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at t=%0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // Model: outputs scheduled by absolute cycle, derived from the arbitration rules
  int         cyc = 0;
  int         cpu_free = 0;
  bit         pend = 0;
  int         wait_m = 0;
  bit         s_vid   [4];
  logic [7:0] s_vdata [4];
  bit         s_ack   [4];
  bit         s_rd    [4];
  logic [7:0] s_cdata [4];
  logic [7:0] vid_hold = 8'h00;
  logic [7:0] rd_hold  = 8'h00;

  always @(negedge clk) begin
    bit vid, cpu_go, idle, blank;
    int k, k2;
    k = cyc & 3;
    if (!rst_n) begin
      for (int j = 0; j < 4; j++) begin
        s_vid[j] = 0; s_ack[j] = 0; s_rd[j] = 0;
      end
      cpu_free = 0; pend = 0; wait_m = 0; vid_hold = 8'h00; rd_hold = 8'h00;
      check("rst_mem_en",    32'(bus.o_mem_en),    0);
      check("rst_mem_we",    32'(bus.o_mem_we),    0);
      check("rst_mem_addr",  32'(bus.o_mem_addr),  0);
      check("rst_vid_valid", 32'(bus.o_vid_valid), 0);
      check("rst_vid_data",  32'(bus.o_vid_data),  0);
      check("rst_cpu_ack",   32'(bus.o_cpu_ack),   0);
      check("rst_cpu_rdata", 32'(bus.o_cpu_rdata), 0);
      check("rst_cpu_wait",  32'(bus.o_cpu_wait),  0);
    end else begin
      vid    = bus.i_vid_req;
      idle   = (cyc >= cpu_free);
      blank  = (ANYTIME != 0) || bus.i_hblank || bus.i_vblank;
      cpu_go = idle && bus.i_cpu_req && blank && !vid;

      check("m_mem_en", 32'(bus.o_mem_en), 32'(vid || cpu_go));
      check("m_mem_we", 32'(bus.o_mem_we), 32'(cpu_go && bus.i_cpu_we));
      if (vid)    check("m_mem_addr", 32'(bus.o_mem_addr), 32'(bus.i_vid_addr));
      if (cpu_go) check("m_mem_addr", 32'(bus.o_mem_addr), 32'(bus.i_cpu_addr));
      if (cpu_go && bus.i_cpu_we) check("m_mem_wdata", 32'(bus.o_mem_wdata), 32'(bus.i_cpu_wdata));

      if (s_vid[k]) vid_hold = s_vdata[k];
      if (s_ack[k] && s_rd[k]) rd_hold = s_cdata[k];
      check("m_vid_valid", 32'(bus.o_vid_valid), 32'(s_vid[k]));
      check("m_vid_data",  32'(bus.o_vid_data),  32'(vid_hold));
      check("m_cpu_ack",   32'(bus.o_cpu_ack),   32'(s_ack[k]));
      check("m_cpu_rdata", 32'(bus.o_cpu_rdata), 32'(rd_hold));
      check("m_cpu_wait",  32'(bus.o_cpu_wait),  32'(wait_m));

      s_vid[k] = 0; s_ack[k] = 0; s_rd[k] = 0;
      k2 = (cyc + 2) & 3;
      if (vid) begin
        s_vid[k2]   = 1;
        s_vdata[k2] = mram[bus.i_vid_addr];
      end
      if (cpu_go) begin
        s_ack[k2]   = 1;
        s_rd[k2]    = !bus.i_cpu_we;
        s_cdata[k2] = mram[bus.i_cpu_addr];
        if (bus.i_cpu_we) mram[bus.i_cpu_addr] = bus.i_cpu_wdata;
        cpu_free = cyc + 3;
      end
      if (idle && bus.i_cpu_req) begin
        if (!pend)        wait_m = cpu_go ? 0 : 1;
        else if (!cpu_go) wait_m = (wait_m < WMAX) ? wait_m + 1 : WMAX;
        pend = !cpu_go;
      end else begin
        pend = 0;
      end
    end
    cyc++;
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_hblank = 0; bus.i_vblank = 0; bus.i_vid_req = 0; bus.i_vid_addr = '0;
    bus.i_cpu_req = 0; bus.i_cpu_we = 0; bus.i_cpu_addr = '0; bus.i_cpu_wdata = '0;
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) begin
      ram[a]  = 8'(a);
      mram[a] = 8'(a);
    end
    ram[16'h1234]  = 8'hA5;
    mram[16'h1234] = 8'hA5;
    bus.i_mem_rdata = '0;
    idle_inputs();
    rst_n = 0;
    repeat (3) next();
    check("reset_wait", 32'(bus.o_cpu_wait), 0);
    rst_n = 1;
    repeat (2) next();

    // Video burst 0x0100..0x0109; RAM returns addr[7:0]
    for (int i = 0; i < 13; i++) begin
      bus.i_vid_req  = (i < 10);
      bus.i_vid_addr = 16'h0100 + 16'(i);
      #3;
      check("burst_valid", 32'(bus.o_vid_valid), 32'((i >= 2) && (i < 12)));
      if (i >= 2 && i < 12) check("burst_data", 32'(bus.o_vid_data), 32'(i - 2));
      next();
    end
    idle_inputs();
    repeat (2) next();

    // CPU write requested while visible; hblank rises at cycle 5
    for (int i = 0; i < 9; i++) begin
      bus.i_hblank = (i >= 5);
      bus.i_cpu_req = (i <= 7); bus.i_cpu_we = 1;
      bus.i_cpu_addr = 16'h0040; bus.i_cpu_wdata = 8'h5A;
      #3;
      if (i < 5)  check("wr_no_issue", 32'(bus.o_mem_en), 0);
      if (i == 5) check("wr_issue_we", 32'(bus.o_mem_we), 1);
      if (i == 6) check("wr_no_ack",   32'(bus.o_cpu_ack), 0);
      if (i == 7) begin
        check("wr_ack",  32'(bus.o_cpu_ack), 1);
        check("wr_wait", 32'(bus.o_cpu_wait), 5);
      end
      next();
    end
    idle_inputs();
    repeat (2) next();

    // Contention in hblank: video wins cycle 0, CPU read issues cycle 1
    for (int i = 0; i < 5; i++) begin
      bus.i_hblank = 1;
      bus.i_vid_req = (i == 0); bus.i_vid_addr = 16'h0200;
      bus.i_cpu_req = (i <= 3); bus.i_cpu_we = 0; bus.i_cpu_addr = 16'h1234;
      #3;
      if (i == 0) begin
        check("cont_vid_we",   32'(bus.o_mem_we),   0);
        check("cont_vid_addr", 32'(bus.o_mem_addr), 32'h0200);
      end
      if (i == 1) check("cont_cpu_addr", 32'(bus.o_mem_addr), 32'h1234);
      if (i == 2) check("cont_vid_data", 32'(bus.o_vid_data), 32'h00);
      if (i == 3) begin
        check("cont_ack",   32'(bus.o_cpu_ack),   1);
        check("cont_wait",  32'(bus.o_cpu_wait),  1);
        check("cont_rdata", 32'(bus.o_cpu_rdata), 32'hA5);
      end
      next();
    end
    idle_inputs();
    repeat (2) next();

    // Read in vblank with req held past ack: reissue at ack+1
    for (int i = 0; i < 8; i++) begin
      bus.i_vblank = 1;
      bus.i_cpu_req = (i <= 5); bus.i_cpu_we = 0; bus.i_cpu_addr = 16'h1234;
      #3;
      if (i == 0) check("rd_issue0",  32'(bus.o_mem_en), 1);
      if (i == 1) begin
        check("rd_busy_no_en", 32'(bus.o_mem_en), 0);
        check("rd_wait0",      32'(bus.o_cpu_wait), 0);
      end
      if (i == 2) begin
        check("rd_ack0",   32'(bus.o_cpu_ack),   1);
        check("rd_rdata0", 32'(bus.o_cpu_rdata), 32'hA5);
        check("rd_ack_no_en", 32'(bus.o_mem_en), 0);
      end
      if (i == 3) check("rd_issue1", 32'(bus.o_mem_en), 1);
      if (i == 5) check("rd_ack1",   32'(bus.o_cpu_ack), 1);
      next();
    end
    idle_inputs();
    repeat (2) next();

    // Wait-counter saturation over 20 visible cycles, then grant in hblank
    for (int i = 0; i < 24; i++) begin
      bus.i_hblank = (i >= 20);
      bus.i_cpu_req = (i <= 22); bus.i_cpu_we = 1;
      bus.i_cpu_addr = 16'h0300; bus.i_cpu_wdata = 8'h77;
      #3;
      if (i == 18) check("sat_wait", 32'(bus.o_cpu_wait), 15);
      if (i == 19) check("sat_no_issue", 32'(bus.o_mem_en), 0);
      if (i == 20) check("sat_issue", 32'(bus.o_mem_we), 1);
      if (i == 22) begin
        check("sat_ack",  32'(bus.o_cpu_ack), 1);
        check("sat_wait_hold", 32'(bus.o_cpu_wait), 15);
      end
      next();
    end
    idle_inputs();
    repeat (2) next();

    // Spurious drop before grant: abandoned silently, count holds
    for (int i = 0; i < 6; i++) begin
      bus.i_cpu_req = (i <= 2); bus.i_cpu_addr = 16'h0050;
      #3;
      check("drop_no_issue", 32'(bus.o_mem_en), 0);
      if (i == 5) check("drop_wait", 32'(bus.o_cpu_wait), 3);
      next();
    end
    idle_inputs();
    repeat (2) next();

    // Reset one cycle after a CPU read issue: no ack, clean restart
    for (int i = 0; i < 8; i++) begin
      rst_n = !(i == 1 || i == 2);
      bus.i_vblank  = (i == 0) || (i >= 4 && i <= 6);
      bus.i_cpu_req = (i == 0) || (i >= 4 && i <= 6);
      bus.i_cpu_we = 0; bus.i_cpu_addr = 16'h1234;
      #3;
      if (i == 1) begin
        check("rstmid_ack",   32'(bus.o_cpu_ack),   0);
        check("rstmid_rdata", 32'(bus.o_cpu_rdata), 0);
        check("rstmid_wait",  32'(bus.o_cpu_wait),  0);
      end
      if (i == 2) check("rstmid_no_ack", 32'(bus.o_cpu_ack), 0);
      if (i == 4) check("rstmid_issue",  32'(bus.o_mem_en),  1);
      if (i == 6) begin
        check("rstmid_ack2",   32'(bus.o_cpu_ack),   1);
        check("rstmid_rdata2", 32'(bus.o_cpu_rdata), 32'hA5);
      end
      next();
    end
    idle_inputs();
    repeat (3) next();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares one single-port synchronous video RAM between the pixel-fetch path (driven by sync-generator timing) and a CPU-side requester.
- Video fetches have absolute priority. CPU accesses are admitted only in cycles with no video fetch, and, by default, only during horizontal/vertical blanking.
- Sits between `video_sync_generator` (blank/visible inputs), the pixel fetch logic and the CPU bus bridge.

Parameters:
- ADDR_WIDTH, 16, VRAM address width.
- DATA_WIDTH, 8, VRAM data width.
- CPU_ANY_TIME, 0, 0: CPU admitted only while i_hblank|i_vblank; 1: CPU admitted in any cycle without a video fetch.
- WAIT_WIDTH, 16, width of the CPU wait-cycle counter.

Ports:
- i_clk  in  1  system/pixel clock
- i_rst_n  in  1  asynchronous active-low reset
- i_hblank  in  1  horizontal blank, from sync generator
- i_vblank  in  1  vertical blank, from sync generator
- i_vid_req  in  1  video fetch request, single-cycle per fetch, never stalled
- i_vid_addr  in  ADDR_WIDTH  video fetch address
- o_vid_valid  out  1  video read data valid
- o_vid_data  out  DATA_WIDTH  video read data
- i_cpu_req  in  1  CPU request, held high until o_cpu_ack
- i_cpu_we  in  1  1 = write, 0 = read; stable while req
- i_cpu_addr  in  ADDR_WIDTH  CPU address; stable while req
- i_cpu_wdata  in  DATA_WIDTH  CPU write data; stable while req
- o_cpu_ack  out  1  one-cycle completion pulse
- o_cpu_rdata  out  DATA_WIDTH  CPU read data, valid with ack
- o_cpu_wait  out  WAIT_WIDTH  cycles the current/last CPU request waited before issue, saturating
- o_mem_en  out  1  memory access enable
- o_mem_we  out  1  memory write enable
- o_mem_addr  out  ADDR_WIDTH  memory address
- o_mem_wdata  out  DATA_WIDTH  memory write data
- i_mem_rdata  in  DATA_WIDTH  memory read data, valid the cycle after o_mem_en (read)

Behaviour:
- Reset (async assert, sync release): all outputs 0; pipeline tags cleared; FSM in IDLE; in-flight accesses dropped with no ack/valid.
- Memory outputs are combinational from the current-cycle grant.
- Grant per cycle:
  - If i_vid_req: video issue (o_mem_en=1, we=0, addr=i_vid_addr).
  - Else if the CPU is grantable: CPU issue (en=1, we=i_cpu_we, addr/wdata from the CPU port).
  - Else o_mem_en=0.
  - CPU is grantable when FSM=IDLE && i_cpu_req && (CPU_ANY_TIME || i_hblank || i_vblank).
- FSM: IDLE -> CPU_BUSY on CPU issue; CPU_BUSY -> CPU_ACK after 1 cycle; CPU_ACK -> IDLE (o_cpu_ack=1 in CPU_ACK).
  - No new CPU grant in CPU_BUSY or CPU_ACK; the next CPU issue is possible at the earliest the cycle after ack.
- Two-stage tag pipeline {valid, owner}, advanced every cycle. Stage 1 samples i_mem_rdata into the output register.
  - Video: issue cycle N -> o_vid_valid=1 and o_vid_data at N+2, exactly one cycle per issue.
  - Back-to-back video requests give back-to-back valids.
- CPU: issue N -> o_cpu_ack at N+2. For reads, o_cpu_rdata = registered data at N+2; for writes, o_cpu_rdata holds its previous value.
  - The requester may drop i_cpu_req in the ack cycle. A req still high after ack is treated as a new request.
- Once issued, a CPU access completes even if blanking ends or video requests arrive during BUSY/ACK.
- Wait counter: cleared on the cycle a CPU request is first seen in IDLE; +1 each cycle the request is pending but not granted; saturates at all-ones; holds after issue until the next request.
- A video request and a grantable CPU request in the same cycle: video wins, CPU waits (counter increments).
- i_cpu_req low: no CPU issue; a spurious req drop before grant is allowed and abandons the request silently.

Test Plan:
- Reset mid-operation: CPU read issued, assert i_rst_n=0 at N+1 -> no o_cpu_ack, all outputs 0; after release, IDLE, next request acked normally at issue+2.
- Video burst: i_vid_req high 10 cycles, addrs 0x0100..0x0109, memory returns addr[7:0] -> o_vid_valid high 10 cycles starting 2 cycles later, data 0x00..0x09 in order.
- CPU write during visible, CPU_ANY_TIME=0: req at cycle 0 with blanks low, hblank rises at cycle 5 -> o_mem_we=1 at cycle 5, o_cpu_ack at 7, o_cpu_wait=5.
- Contention in blank: i_hblank=1, vid_req and cpu_req both high cycle 0, vid_req low cycle 1 -> video issue cycle 0, CPU issue cycle 1, ack cycle 3, wait=1.
- CPU read data: memory holds 0xA5 at 0x1234, read in vblank -> o_cpu_ack with o_cpu_rdata=0xA5 two cycles after issue; req held high after ack -> second issue no earlier than ack+1.
- Saturation: WAIT_WIDTH=4, CPU req held through 20 non-blank cycles -> o_cpu_wait sticks at 15, then grants at first blank.
